// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 64-point FFT output reorder buffer.
package fft_pkg;

    localparam int DATA_W = 24;
    localparam int N      = 64;
    localparam int LOG2N  = 6;
    localparam int WORD_W = 2 * DATA_W;

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Read-side FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // LOG2N-bit bit reversal: maps a natural bin index to its arrival slot
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// One reorder bank: N x {re,im} simple dual-port RAM, one write port,
// one read port with registered output data.
module fft_bank_ram
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [LOG2N-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [LOG2N-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [N];

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; rdata holds when not reading
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft64_bitrev_reorder.sv
// Output-side reorder buffer for the 64-point SDF FFT. Samples arrive in
// bit-reversed bin order and are written linearly into one bank while the
// other bank is read at bit-reversed addresses, yielding natural order.
//
//  state   | meaning
//  IDLE    | no full bank pending, read side quiet
//  READ    | streaming N reads from rd_bank, rd_cnt 0..N-1
//
// Pipeline: handover edge -> RAM read edge -> output register edge, so the
// first out_valid appears on the second edge after sample N-1 is accepted.
module fft64_bitrev_reorder
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din_r,
    input  logic [DATA_W-1:0] din_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout_r,
    output logic [DATA_W-1:0] dout_i,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last
);

    logic [LOG2N-1:0]  wr_cnt;
    logic              wr_bank;
    logic [0:0]        rd_state;
    logic [LOG2N-1:0]  rd_cnt;
    logic              rd_bank;
    logic              s1_valid;
    logic [LOG2N-1:0]  s1_idx;
    logic              s1_bank;

    logic              wr_en;
    logic              handover;
    logic              reading;
    logic [LOG2N-1:0]  rd_addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata0;
    logic [WORD_W-1:0] rdata1;
    logic [WORD_W-1:0] rdata_sel;

    assign wr_en     = in_valid && !rst;
    assign handover  = wr_en && (wr_cnt == LAST_IDX);
    assign reading   = (rd_state == ST_READ) && !rst;
    assign rd_addr   = bitrev(rd_cnt);
    assign wdata     = {din_r, din_i};
    assign rdata_sel = s1_bank ? rdata1 : rdata0;

    fft_bank_ram u_bank0 (
        .clk   (clk),
        .we    (wr_en && !wr_bank),
        .waddr (wr_cnt),
        .wdata (wdata),
        .re    (reading && !rd_bank),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    fft_bank_ram u_bank1 (
        .clk   (clk),
        .we    (wr_en && wr_bank),
        .waddr (wr_cnt),
        .wdata (wdata),
        .re    (reading && rd_bank),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    // Write side: linear address, bank toggles on the last sample of a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_cnt == LAST_IDX) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM: a handover restarts reading, which also covers the
    // back-to-back case where it coincides with the last read of the previous bank
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= ST_IDLE;
            rd_cnt   <= '0;
            rd_bank  <= 1'b0;
        end else if (handover) begin
            rd_state <= ST_READ;
            rd_cnt   <= '0;
            rd_bank  <= wr_bank;
        end else if (rd_state == ST_READ) begin
            if (rd_cnt == LAST_IDX) begin
                rd_state <= ST_IDLE;
            end
            rd_cnt <= rd_cnt + LOG2N'(1);
        end
    end

    // Track index and bank alongside the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_bank  <= 1'b0;
        end else begin
            s1_valid <= (rd_state == ST_READ);
            s1_idx   <= rd_cnt;
            s1_bank  <= rd_bank;
        end
    end

    // Output register; data and index hold while out_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            dout_r    <= '0;
            dout_i    <= '0;
        end else begin
            out_valid <= s1_valid;
            out_last  <= s1_valid && (s1_idx == LAST_IDX);
            if (s1_valid) begin
                out_idx <= s1_idx;
                dout_r  <= rdata_sel[WORD_W-1:DATA_W];
                dout_i  <= rdata_sel[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fft64_bitrev_reorder.sv
// Scoreboard bench for fft64_bitrev_reorder: a reference model pushes the
// expected natural-order frame (with expected output cycles) when it sees a
// frame complete; an independent monitor pops and compares on out_valid.
module tb_fft64_bitrev_reorder;
    import fft_pkg::*;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        int                idx;
        logic              last;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] din_r = '0;
    logic [DATA_W-1:0] din_i = '0;
    logic              out_valid;
    logic [DATA_W-1:0] dout_r;
    logic [DATA_W-1:0] dout_i;
    logic [LOG2N-1:0]  out_idx;
    logic              out_last;

    int vectors = 0;
    int miscompares = 0;
    int edge_no = 0;
    int model_cnt = 0;
    logic [DATA_W-1:0] re_buf [N];
    logic [DATA_W-1:0] im_buf [N];
    exp_t sb [$];

    fft64_bitrev_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic int tb_rev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Reference model: mirrors acceptance, builds expected frame on sample N-1
    always @(posedge clk) begin
        edge_no <= edge_no + 1;
        if (rst) begin
            model_cnt <= 0;
            sb.delete();
        end else if (in_valid) begin
            re_buf[model_cnt] <= din_r;
            im_buf[model_cnt] <= din_i;
            if (model_cnt == N - 1) begin
                for (int n = 0; n < N; n++) begin
                    exp_t e;
                    int   src;
                    src    = tb_rev(n);
                    e.re   = (src == N - 1) ? din_r : re_buf[src];
                    e.im   = (src == N - 1) ? din_i : im_buf[src];
                    e.idx  = n;
                    e.last = (n == N - 1);
                    e.cyc  = edge_no + 1 + 2 + n;
                    sb.push_back(e);
                end
                model_cnt <= 0;
            end else begin
                model_cnt <= model_cnt + 1;
            end
        end
    end

    // Monitor: compare every presented output against the scoreboard head
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output idx=%0d re=%h im=%h at edge %0d", out_idx, dout_r, dout_i, edge_no);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (dout_r !== e.re || dout_i !== e.im || int'(out_idx) != e.idx ||
                        out_last !== e.last || edge_no != e.cyc) begin
                        miscompares++;
                        $display("FAIL output got re=%h im=%h idx=%0d last=%b edge=%0d expected re=%h im=%h idx=%0d last=%b edge=%0d",
                                 dout_r, dout_i, out_idx, out_last, edge_no, e.re, e.im, e.idx, e.last, e.cyc);
                    end
                end
            end else begin
                vectors++;
                if (out_last !== 1'b0 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_flags got valid=%b last=%b expected valid=0 last=0 at edge %0d", out_valid, out_last, edge_no);
                end
            end
        end
    end

    // Drive nsamp samples; ext puts the extreme pair at arrival 1
    task automatic send_frame(input int base, input int gap, input bit ext, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            din_r    = DATA_W'(base + k);
            din_i    = DATA_W'(-(base + k));
            if (ext && k == 1) begin
                din_r = 24'h7FFFFF;
                din_i = 24'h800000;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && sb.size() > 0; t++) @(negedge clk);
        vectors++;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout got %0d outputs pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // 1: reset held with in_valid active
        rst      = 1'b1;
        in_valid = 1'b1;
        din_r    = 24'h123456;
        din_i    = 24'h654321;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0 || dout_r !== '0 || dout_i !== '0 || out_idx !== '0) begin
                miscompares++;
                $display("FAIL reset_state got valid=%b re=%h im=%h idx=%0d expected all zero",
                         out_valid, dout_r, dout_i, out_idx);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // 2: single frame, re=k im=-k
        send_frame(0, 0, 1'b0, N);
        wait_drain();

        // 3: three back-to-back frames
        send_frame(1000, 0, 1'b0, 3 * N);
        wait_drain();

        // 4: gapped input, one sample every third cycle
        send_frame(0, 2, 1'b0, N);
        wait_drain();

        // 5: partial frame discarded by reset, then a fresh frame
        send_frame(3000, 0, 1'b0, 40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_frame(5000, 0, 1'b0, N);
        wait_drain();

        // 6: full-scale extremes at arrival 1 (natural bin 32)
        send_frame(200, 0, 1'b1, N);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
